// File: rtl/apple_pkg.sv
// apple_pkg: shared definitions for the falling-apple controller.
//   - apple_state_e : FSM state encoding (HANG/FALL/GONE; 3 is unused)
//   - SCREEN_H/SPRITE_H : vertical bounds used to retire a falling apple
//   - X_W/Y_W/VEL_W : column, signed row and velocity widths
package apple_pkg;

  localparam int X_W      = 10;
  localparam int Y_W      = 11;
  localparam int VEL_W    = 4;
  localparam int SCREEN_H = 480;
  localparam int SPRITE_H = 32;

  typedef enum logic [1:0] {
    ST_HANG = 2'd0,
    ST_FALL = 2'd1,
    ST_GONE = 2'd2
  } apple_state_e;

endpackage

// File: rtl/apple_gravity.sv
// apple_gravity: combinational single-step gravity update.
//   vel           : current velocity (unsigned, pixels per tick)
//   y             : current signed sprite row
//   vel_next      : min(vel + GRAV, VMAX)
//   y_next        : y moved by vel_next (down for DIR=0, up for DIR=1)
//   out_of_bounds : y_next has left the screen in the fall direction
module apple_gravity
  import apple_pkg::*;
#(
  parameter int DIR  = 0,
  parameter int GRAV = 1,
  parameter int VMAX = 8
) (
  input  logic        [VEL_W-1:0] vel,
  input  logic signed [Y_W-1:0]   y,
  output logic        [VEL_W-1:0] vel_next,
  output logic signed [Y_W-1:0]   y_next,
  output logic                    out_of_bounds
);

  // One extra bit of headroom so the bound check can never see a wrapped value.
  localparam logic signed [Y_W:0] Y_LIMIT_DOWN = (Y_W + 1)'(SCREEN_H);
  localparam logic signed [Y_W:0] Y_LIMIT_UP   = (Y_W + 1)'(-SPRITE_H);

  int                  vel_sum;
  logic signed [Y_W:0] y_wide;
  logic signed [Y_W:0] vel_wide;

  always_comb begin
    // Saturate in full integer width so a large GRAV cannot wrap the 4-bit register.
    vel_sum  = int'(vel) + GRAV;
    vel_next = (vel_sum > VMAX) ? VEL_W'(VMAX) : VEL_W'(vel_sum);

    vel_wide = $signed({{(Y_W + 1 - VEL_W){1'b0}}, vel_next});
    if (DIR == 0) begin
      y_wide        = $signed({y[Y_W-1], y}) + vel_wide;
      out_of_bounds = (y_wide >= Y_LIMIT_DOWN);
    end else begin
      y_wide        = $signed({y[Y_W-1], y}) - vel_wide;
      out_of_bounds = (y_wide <= Y_LIMIT_UP);
    end
    y_next = y_wide[Y_W-1:0];
  end

endmodule

// File: rtl/apple_ctrl.sv
// apple_ctrl: falling-apple sprite controller.
//   clk, rst    : clock and synchronous active-high reset (highest priority)
//   update_tick : frame-update strobe; triggers the fall and advances motion
//   toggle_tick : animation strobe; flips anim_frame while hanging
//   kid_x       : kid column, compared against [TRIG_LO, TRIG_HI]
//   respawn     : re-arms the apple to its rest position (beats all ticks)
//   apple_x     : constant sprite column INIT_X
//   apple_y     : signed sprite row
//   anim_frame  : sprite frame select
//   active      : apple visible and lethal (HANG or FALL)
//   state       : current FSM state, exported for observation
// All inputs are single-cycle strobes sampled on the rising edge; there is no
// handshake, every asserted strobe is consumed in the cycle it is seen.
module apple_ctrl
  import apple_pkg::*;
#(
  parameter int INIT_X  = 64,
  parameter int INIT_Y  = 91,
  parameter int TRIG_LO = 48,
  parameter int TRIG_HI = 80,
  parameter int DIR     = 0,
  parameter int GRAV    = 1,
  parameter int VMAX    = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  update_tick,
  input  logic                  toggle_tick,
  input  logic [X_W-1:0]        kid_x,
  input  logic                  respawn,
  output logic [X_W-1:0]        apple_x,
  output logic signed [Y_W-1:0] apple_y,
  output logic                  anim_frame,
  output logic                  active,
  output logic [1:0]            state
);

  localparam logic signed [Y_W-1:0] Y_REST = Y_W'(INIT_Y);

  apple_state_e            state_q, state_d;
  logic signed [Y_W-1:0]   y_q, y_d;
  logic        [VEL_W-1:0] vel_q, vel_d;
  logic                    anim_q, anim_d;

  logic        [VEL_W-1:0] vel_step;
  logic signed [Y_W-1:0]   y_step;
  logic                    step_oob;
  logic                    kid_in_window;

  apple_gravity #(
    .DIR  (DIR),
    .GRAV (GRAV),
    .VMAX (VMAX)
  ) u_gravity (
    .vel           (vel_q),
    .y             (y_q),
    .vel_next      (vel_step),
    .y_next        (y_step),
    .out_of_bounds (step_oob)
  );

  assign kid_in_window = (int'(kid_x) >= TRIG_LO) && (int'(kid_x) <= TRIG_HI);

  always_comb begin
    state_d = state_q;
    y_d     = y_q;
    vel_d   = vel_q;
    anim_d  = anim_q;

    if (respawn) begin
      state_d = ST_HANG;
      y_d     = Y_REST;
      vel_d   = '0;
      anim_d  = 1'b0;
    end else begin
      // Animation only runs while hanging; it is independent of update_tick.
      if (toggle_tick && (state_q == ST_HANG)) begin
        anim_d = ~anim_q;
      end

      case (state_q)
        ST_HANG: begin
          // The triggering tick only changes state; motion starts on the next tick.
          if (update_tick && kid_in_window) begin
            state_d = ST_FALL;
          end
        end
        ST_FALL: begin
          if (update_tick) begin
            vel_d = vel_step;
            y_d   = y_step;
            if (step_oob) begin
              state_d = ST_GONE;
            end
          end
        end
        ST_GONE: begin
          // Parked off-screen until respawn or reset.
        end
        default: begin
          state_d = ST_HANG;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_HANG;
      y_q     <= Y_REST;
      vel_q   <= '0;
      anim_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      y_q     <= y_d;
      vel_q   <= vel_d;
      anim_q  <= anim_d;
    end
  end

  assign apple_x    = X_W'(INIT_X);
  assign apple_y    = y_q;
  assign anim_frame = anim_q;
  assign active     = (state_q == ST_HANG) || (state_q == ST_FALL);
  assign state      = state_q;

endmodule

// File: tb/tb_apple_ctrl.sv
// tb_apple_ctrl: two controllers (DIR=0 and DIR=1) share one stimulus stream.
// A vector table drives the documented down-fall scenarios, a hand sequence
// covers the upward fall, and a random phase compares both against an
// integer reference model.
module tb_apple_ctrl;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, update_tick, toggle_tick, respawn;
  logic [9:0]  kid_x;

  logic [9:0]         apple_x0, apple_x1;
  logic signed [10:0] apple_y0, apple_y1;
  logic               anim0, anim1, active0, active1;
  logic [1:0]         state0, state1;

  apple_ctrl dut0 (
    .clk(clk), .rst(rst), .update_tick(update_tick), .toggle_tick(toggle_tick),
    .kid_x(kid_x), .respawn(respawn), .apple_x(apple_x0), .apple_y(apple_y0),
    .anim_frame(anim0), .active(active0), .state(state0)
  );

  apple_ctrl #(.DIR(1)) dut1 (
    .clk(clk), .rst(rst), .update_tick(update_tick), .toggle_tick(toggle_tick),
    .kid_x(kid_x), .respawn(respawn), .apple_x(apple_x1), .apple_y(apple_y1),
    .anim_frame(anim1), .active(active1), .state(state1)
  );

  // ---------------- scoreboard counters ----------------
  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------- reference model (integer arithmetic) ----------------
  // index 0 = falls down, index 1 = falls up
  int m_st[2], m_y[2], m_vel[2], m_anim[2];

  function automatic void model_step(input int d, input bit r, input bit u,
                                     input bit t, input bit p, input int kid);
    if (r || p) begin
      m_st[d] = 0; m_y[d] = 91; m_vel[d] = 0; m_anim[d] = 0;
      return;
    end
    if (t && m_st[d] == 0) m_anim[d] = 1 - m_anim[d];
    if (u) begin
      if (m_st[d] == 0) begin
        if (kid >= 48 && kid <= 80) m_st[d] = 1;
      end else if (m_st[d] == 1) begin
        m_vel[d] = (m_vel[d] + 1 > 8) ? 8 : m_vel[d] + 1;
        m_y[d]   = (d == 0) ? m_y[d] + m_vel[d] : m_y[d] - m_vel[d];
        if ((d == 0 && m_y[d] >= 480) || (d == 1 && m_y[d] <= -32)) m_st[d] = 2;
      end
    end
  endfunction

  task automatic check_model();
    chk("m0_state", int'(state0), m_st[0]);
    chk("m0_y", int'(apple_y0), m_y[0]);
    chk("m0_anim", int'(anim0), m_anim[0]);
    chk("m0_active", int'(active0), (m_st[0] != 2) ? 1 : 0);
    chk("m0_x", int'(apple_x0), 64);
    chk("m1_state", int'(state1), m_st[1]);
    chk("m1_y", int'(apple_y1), m_y[1]);
    chk("m1_anim", int'(anim1), m_anim[1]);
    chk("m1_active", int'(active1), (m_st[1] != 2) ? 1 : 0);
    chk("m1_x", int'(apple_x1), 64);
  endtask

  // ---------------- driver ----------------
  // Inputs change 1 time unit after the rising edge; outputs sampled there too.
  task automatic cycle(input bit r, input bit u, input bit t, input bit p, input int kid);
    rst = r; update_tick = u; toggle_tick = t; respawn = p; kid_x = 10'(kid);
    model_step(0, r, u, t, p, kid);
    model_step(1, r, u, t, p, kid);
    @(posedge clk);
    #1;
    rst = 1'b0; update_tick = 1'b0; toggle_tick = 1'b0; respawn = 1'b0;
    check_model();
  endtask

  // ---------------- vector table (expectations for the DIR=0 unit) ----------------
  typedef struct {
    bit rst; bit upd; bit tog; bit resp; int kid;
    int exp_st; int exp_y; int exp_anim;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input bit r, input bit u, input bit t, input bit p,
                              input int kid, input int st, input int y, input int an);
    vec_t v;
    v.rst = r; v.upd = u; v.tog = t; v.resp = p; v.kid = kid;
    v.exp_st = st; v.exp_y = y; v.exp_anim = an;
    tbl.push_back(v);
  endfunction

  initial begin
    int exp_y8[8];
    exp_y8 = '{92, 94, 97, 101, 106, 112, 119, 127};
    rst = 1'b1; update_tick = 1'b0; toggle_tick = 1'b0; respawn = 1'b0; kid_x = '0;

    // reset, idle, toggle while hanging, trigger with kid_x=60
    add(1, 0, 0, 0, 60, 0, 91, 0);
    add(0, 0, 0, 0, 60, 0, 91, 0);
    add(0, 0, 1, 0, 0,  0, 91, 1);
    add(0, 1, 0, 0, 60, 1, 91, 1);
    add(0, 0, 1, 0, 60, 1, 91, 1);
    for (int k = 0; k < 8; k++) add(0, 1, 0, 0, 60, 1, exp_y8[k], 1);
    // velocity saturated at 8: 45 more ticks, GONE at 487 on tick 53
    for (int k = 1; k <= 45; k++) add(0, 1, 0, 0, 60, (k == 45) ? 2 : 1, 127 + 8 * k, 1);
    for (int k = 0; k < 3; k++) add(0, 1, 1, 0, 60, 2, 487, 1);
    // respawn beats update; trigger window edges
    add(0, 1, 0, 1, 60, 0, 91, 0);
    add(0, 1, 0, 0, 47, 0, 91, 0);
    add(0, 1, 0, 0, 81, 0, 91, 0);
    add(0, 1, 0, 0, 48, 1, 91, 0);
    add(0, 1, 0, 0, 48, 1, 92, 0);
    add(0, 1, 0, 0, 48, 1, 94, 0);
    // mid-fall respawn with update: velocity must restart from zero
    add(0, 1, 1, 1, 60, 0, 91, 0);
    add(0, 1, 0, 0, 80, 1, 91, 0);
    add(0, 1, 0, 0, 80, 1, 92, 0);
    // toggle and update together in HANG; reset mid-fall; reset beats ticks
    add(0, 0, 0, 1, 60, 0, 91, 0);
    add(0, 1, 1, 0, 60, 1, 91, 1);
    add(0, 1, 0, 0, 60, 1, 92, 1);
    add(1, 0, 0, 0, 60, 0, 91, 0);
    add(0, 1, 1, 0, 60, 1, 91, 1);
    add(1, 1, 1, 1, 60, 0, 91, 0);

    foreach (tbl[i]) begin
      cycle(tbl[i].rst, tbl[i].upd, tbl[i].tog, tbl[i].resp, tbl[i].kid);
      chk($sformatf("tbl%0d_state", i), int'(state0), tbl[i].exp_st);
      chk($sformatf("tbl%0d_y", i), int'(apple_y0), tbl[i].exp_y);
      chk($sformatf("tbl%0d_anim", i), int'(anim0), tbl[i].exp_anim);
      chk($sformatf("tbl%0d_active", i), int'(active0), (tbl[i].exp_st == 2) ? 0 : 1);
    end

    // upward fall: 91-36=55 after 8 ticks, then -8 per tick, -33 on tick 19
    cycle(0, 0, 0, 1, 60);
    cycle(0, 0, 1, 0, 60);
    chk("up_hang_anim", int'(anim1), 1);
    cycle(0, 1, 0, 0, 60);
    chk("up_trig_state", int'(state1), 1);
    chk("up_trig_y", int'(apple_y1), 91);
    cycle(0, 0, 1, 0, 60);
    chk("up_fall_anim_hold", int'(anim1), 1);
    for (int k = 1; k <= 18; k++) cycle(0, 1, 0, 0, 60);
    chk("up_t18_state", int'(state1), 1);
    chk("up_t18_y", int'(apple_y1), -25);
    cycle(0, 1, 0, 0, 60);
    chk("up_t19_state", int'(state1), 2);
    chk("up_t19_y", int'(apple_y1), -33);
    chk("up_t19_active", int'(active1), 0);
    cycle(0, 1, 1, 0, 60);
    chk("up_hold_state", int'(state1), 2);
    chk("up_hold_y", int'(apple_y1), -33);

    // random phase against the model
    for (int n = 0; n < 3000; n++) begin
      cycle(($urandom_range(0, 299) == 0), ($urandom_range(0, 1) == 1),
            ($urandom_range(0, 2) == 0), ($urandom_range(0, 59) == 0),
            int'($urandom_range(30, 100)));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/apple_ctrl.md
APPLE_CTRL -- requirements
Module: apple_ctrl

Interface
REQ-001 Parameter INIT_X, default 64, apple rest column in pixels.
REQ-002 Parameter INIT_Y, default 91, apple rest row in pixels.
REQ-003 Parameter TRIG_LO, default 48, lower bound of the kid_x trigger window, inclusive.
REQ-004 Parameter TRIG_HI, default 80, upper bound of the kid_x trigger window, inclusive.
REQ-005 Parameter DIR, default 0, fall direction: 0 = down, 1 = up.
REQ-006 Parameter GRAV, default 1, velocity increment per update tick, in pixels.
REQ-007 Parameter VMAX, default 8, velocity cap in pixels per tick, range 1..15.
REQ-008 Clocking and reset (already decided): one clock; reset is synchronous and active-high.
REQ-009 Port clk, input, 1, system clock.
REQ-010 Port rst, input, 1, synchronous active-high reset.
REQ-011 Port update_tick, input, 1, one-cycle frame-update strobe.
REQ-012 Port toggle_tick, input, 1, one-cycle animation strobe.
REQ-013 Port kid_x, input, 10, kid column.
REQ-014 Port respawn, input, 1, one-cycle strobe that re-arms the apple.
REQ-015 Port apple_x, output, 10, sprite column (always INIT_X).
REQ-016 Port apple_y, output, 11, signed sprite row.
REQ-017 Port anim_frame, output, 1, sprite frame select.
REQ-018 Port active, output, 1, apple visible and lethal.
REQ-019 Port state, output, 2, current FSM state.

Function
REQ-020 FSM states: HANG=0, FALL=1, GONE=2; encoding 3 unused, recovers to HANG on the next clock.
REQ-021 HANG: on update_tick with TRIG_LO <= kid_x <= TRIG_HI, state becomes FALL on the next clock; no motion occurs on that tick.
REQ-022 FALL, on each update_tick: vel = min(vel+GRAV, VMAX); then apple_y += vel (DIR=0) or apple_y -= vel (DIR=1), using the updated vel.
REQ-023 FALL to GONE on the same edge that the new apple_y satisfies apple_y >= 480 (DIR=0) or apple_y <= -32 (DIR=1).
REQ-024 GONE: apple_y and vel hold; active=0; only rst or respawn leave GONE.
REQ-025 active=1 in HANG and FALL.
REQ-026 anim_frame toggles on toggle_tick only in HANG; it holds in FALL and GONE.
REQ-027 respawn in any state: state=HANG, apple_y=INIT_Y, vel=0, anim_frame=0, all on the next clock.
REQ-028 respawn coincident with update_tick: respawn wins and no trigger or motion is applied.
REQ-029 toggle_tick coincident with update_tick: both are honoured independently.
REQ-030 Velocity register is 4 bits unsigned and saturates at VMAX, never wraps.
REQ-031 apple_y arithmetic is 11-bit signed, with range checked against 480 and -32 without overflow.
REQ-032 Ticks are not required to be periodic; back-to-back update_tick pulses each apply one step.

Reset
REQ-033 rst has priority over respawn and all ticks.
REQ-034 Reset values: state=HANG, apple_y=INIT_Y, vel=0, anim_frame=0, active=1, apple_x=INIT_X.
REQ-035 Reset asserted mid-FALL returns the apple to the rest position on the next clock.

Structure
REQ-036 Shared package apple_pkg holds the state encoding, SCREEN_H=480, SPRITE_H=32, and the coordinate width constants.
REQ-037 One sub-module, apple_gravity, implements the combinational saturating velocity/position step and the bound check; the FSM stays in apple_ctrl.

Verification
REQ-038 Defaults, kid_x=60, one update_tick -> state=FALL next clock, apple_y=91 unchanged.
REQ-039 Continue from REQ-038 with update_ticks 1..8 -> apple_y = 92, 94, 97, 101, 106, 112, 119, 127; vel saturates at 8.
REQ-040 Continue from REQ-039 -> GONE on the 53rd FALL tick with apple_y=487, active=0, held on further ticks.
REQ-041 kid_x=47 and kid_x=81 on ticks -> stays HANG; kid_x=48 and kid_x=80 each trigger FALL.
REQ-042 Mid-FALL, respawn coincident with update_tick -> next clock HANG, apple_y=91, vel=0, anim_frame=0.
REQ-043 DIR=1, INIT_Y=91, triggered -> GONE on the same edge that apple_y first reaches <= -32; toggle_tick in HANG flips anim_frame, toggle_tick in FALL does not.
